// File: rtl/trace_bram_writer.sv
// Trace capture: buffers trace elements in a small FIFO and streams them as 32-bit words into a BRAM region.
// Optional macro TRACE_BRAM_WRITER_WRAP_EN turns the region into a ring buffer and adds the sticky `wrapped` output.
module trace_bram_writer #(
    parameter int          TRACE_WIDTH     = 224,
    parameter int          FIFO_DEPTH      = 8,
    parameter int          BRAM_ADDR_WIDTH = 16,
    parameter logic [31:0] END_MARKER      = 32'hFFFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trace_ready,
    input  logic [TRACE_WIDTH-1:0]     ex_data_i,
    input  logic                       repeat_detected,
    output logic                       bram_en,
    output logic [3:0]                 bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]                bram_wdata,
    output logic [31:0]                elements_written,
    output logic [31:0]                dropped_count,
    output logic                       overflow,
    output logic                       bram_full,
    output logic                       done
`ifdef TRACE_BRAM_WRITER_WRAP_EN
    ,
    output logic                       wrapped
`endif
);
    localparam int          WORDS        = TRACE_WIDTH / 32;
    localparam int          KW           = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int          PW           = $clog2(FIFO_DEPTH);
    localparam int          CW           = PW + 1;
    localparam int          MAX_ELEMENTS = ((2 ** BRAM_ADDR_WIDTH) - 4) / (WORDS * 4);
    localparam logic [KW-1:0] LAST_K     = KW'(WORDS - 1);
    localparam logic [31:0] MAX_EL       = 32'(MAX_ELEMENTS);
`ifdef TRACE_BRAM_WRITER_WRAP_EN
    localparam logic [BRAM_ADDR_WIDTH-1:0] RING_END = BRAM_ADDR_WIDTH'(MAX_ELEMENTS * WORDS * 4);
`endif

    typedef enum logic [1:0] {IDLE, WRITE, MARK, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [TRACE_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]              rd_idx_reg, wr_idx_reg;
    logic [CW-1:0]              count_reg;
    logic [TRACE_WIDTH-1:0]     elem_reg;
    logic [KW-1:0]              k_reg;
    logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_reg, addr_reg;
    logic [31:0]                wdata_reg;
    logic [31:0]                elements_reg, dropped_reg;
    logic                       overflow_reg, full_reg, done_reg, wrapped_reg;
    logic [31:0]                elem_words [WORDS];

    logic                       pop, push, drop, accept, flush, last_word, full_set, ring_wrap;
    logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [31:0]                drop_inc;
    logic [32:0]                dropped_sum;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign elem_words[gi] = elem_reg[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        last_word  = (state_reg == WRITE) && (k_reg == LAST_K);
        pop        = (state_reg == IDLE) && (count_reg != '0) && !full_reg;
        // Once full (or finished) nothing new enters the FIFO.
        accept     = (state_reg != DONE) && !full_reg;
        push       = trace_ready && accept && ((count_reg < CW'(FIFO_DEPTH)) || pop);
        drop       = trace_ready && ((accept && !push) || full_reg);
        flush      = (state_reg == MARK) && full_reg;
        wr_ptr_inc = wr_ptr_reg + BRAM_ADDR_WIDTH'(4);
`ifdef TRACE_BRAM_WRITER_WRAP_EN
        ring_wrap  = last_word && (wr_ptr_inc == RING_END);
        full_set   = 1'b0;
`else
        ring_wrap  = 1'b0;
        full_set   = last_word && ((elements_reg + 32'd1) == MAX_EL);
`endif
        drop_inc    = (flush ? 32'(count_reg) : 32'd0) + 32'(drop);
        dropped_sum = {1'b0, dropped_reg} + {1'b0, drop_inc};

        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pop)
                    state_next = WRITE;
                // A strobe coinciding with the request must still be written first.
                else if ((count_reg == '0) && !trace_ready && repeat_detected)
                    state_next = MARK;
            end
            WRITE: begin
                if (last_word)
                    state_next = full_set ? MARK : IDLE;
            end
            MARK:    state_next = DONE;
            default: state_next = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_idx_reg] <= ex_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rd_idx_reg   <= '0;
            wr_idx_reg   <= '0;
            count_reg    <= '0;
            elem_reg     <= '0;
            k_reg        <= '0;
            wr_ptr_reg   <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            elements_reg <= '0;
            dropped_reg  <= '0;
            overflow_reg <= 1'b0;
            full_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wrapped_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                rd_idx_reg <= wr_idx_reg;
                count_reg  <= '0;
            end else begin
                if (push) wr_idx_reg <= wr_idx_reg + PW'(1);
                if (pop)  rd_idx_reg <= rd_idx_reg + PW'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
            if (pop) begin
                elem_reg <= fifo_mem[rd_idx_reg];
                k_reg    <= '0;
            end
            if (bram_en) begin
                addr_reg  <= bram_addr;
                wdata_reg <= bram_wdata;
            end
            if (state_reg == WRITE) begin
                k_reg      <= k_reg + KW'(1);
                wr_ptr_reg <= ring_wrap ? '0 : wr_ptr_inc;
            end
            if (last_word && (elements_reg != '1))
                elements_reg <= elements_reg + 32'd1;
            dropped_reg <= dropped_sum[32] ? '1 : dropped_sum[31:0];
            if (drop_inc != '0)        overflow_reg <= 1'b1;
            if (full_set)              full_reg     <= 1'b1;
            if (state_reg == MARK)     done_reg     <= 1'b1;
            if (ring_wrap)             wrapped_reg  <= 1'b1;
        end
    end

    always_comb begin
        bram_en    = (state_reg == WRITE) || (state_reg == MARK);
        bram_we    = bram_en ? 4'hF : 4'h0;
        bram_addr  = bram_en ? wr_ptr_reg : addr_reg;
        bram_wdata = wdata_reg;
        if (state_reg == WRITE)
            bram_wdata = elem_words[k_reg];
        else if (state_reg == MARK)
            bram_wdata = END_MARKER;
    end

    assign elements_written = elements_reg;
    assign dropped_count    = dropped_reg;
    assign overflow         = overflow_reg;
    assign bram_full        = full_reg;
    assign done             = done_reg;
`ifdef TRACE_BRAM_WRITER_WRAP_EN
    assign wrapped = wrapped_reg;
`else
    logic unused_wrapped;
    assign unused_wrapped = wrapped_reg;
`endif

endmodule

// File: tb/tb_trace_bram_writer.sv
// Directed bench for trace_bram_writer: a 64 KiB instance (a) and a 256 B instance (b) for capacity/wrap cases.
`timescale 1ns/1ps
module tb_trace_bram_writer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    logic         tr_a = 1'b0, rep_a = 1'b0;
    logic [223:0] data_a = '0;
    logic         en_a, ovf_a, full_a, done_a;
    logic [3:0]   we_a;
    logic [15:0]  addr_a;
    logic [31:0]  wdata_a, elem_a, drop_a;

    logic         tr_b = 1'b0, rep_b = 1'b0;
    logic [223:0] data_b = '0;
    logic         en_b, ovf_b, full_b, done_b;
    logic [3:0]   we_b;
    logic [7:0]   addr_b;
    logic [31:0]  wdata_b, elem_b, drop_b;
`ifdef TRACE_BRAM_WRITER_WRAP_EN
    logic         wrapped_a, wrapped_b;
`endif

    logic [31:0] la_addr[$], la_data[$], lb_addr[$], lb_data[$];
    logic [3:0]  la_we[$];
    int          la_cyc[$];

    trace_bram_writer #(.BRAM_ADDR_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .trace_ready(tr_a), .ex_data_i(data_a),
        .repeat_detected(rep_a), .bram_en(en_a), .bram_we(we_a), .bram_addr(addr_a),
        .bram_wdata(wdata_a), .elements_written(elem_a), .dropped_count(drop_a),
        .overflow(ovf_a), .bram_full(full_a), .done(done_a)
`ifdef TRACE_BRAM_WRITER_WRAP_EN
        , .wrapped(wrapped_a)
`endif
    );

    trace_bram_writer #(.BRAM_ADDR_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .trace_ready(tr_b), .ex_data_i(data_b),
        .repeat_detected(rep_b), .bram_en(en_b), .bram_we(we_b), .bram_addr(addr_b),
        .bram_wdata(wdata_b), .elements_written(elem_b), .dropped_count(drop_b),
        .overflow(ovf_b), .bram_full(full_b), .done(done_b)
`ifdef TRACE_BRAM_WRITER_WRAP_EN
        , .wrapped(wrapped_b)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (en_a) begin
            la_addr.push_back(32'(addr_a));
            la_data.push_back(wdata_a);
            la_we.push_back(we_a);
            la_cyc.push_back(cyc);
        end
        if (en_b && we_b == 4'hF) begin
            lb_addr.push_back(32'(addr_b));
            lb_data.push_back(wdata_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tr_a = 1'b0; rep_a = 1'b0; tr_b = 1'b0; rep_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        la_addr.delete(); la_data.delete(); la_we.delete(); la_cyc.delete();
        lb_addr.delete(); lb_data.delete();
    endtask

    // Element tagged `tag`: word j = {tag, j}.
    function automatic logic [223:0] mk(input logic [15:0] tag);
        logic [223:0] r;
        for (int j = 0; j < 7; j++) r[32*j +: 32] = {tag, 16'(j)};
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [15:0] base, input int i);
        return {base + 16'(i / 7), 16'(i % 7)};
    endfunction

    task automatic strobe_a(input logic [223:0] d);
        tr_a = 1'b1; data_a = d;
        step();
        tr_a = 1'b0;
    endtask

    initial begin
        int s;
        int bad;
        logic [223:0] d1;

        // Reset state
        do_reset();
        check("rst_en_a", en_a, 0);
        check("rst_we_a", we_a, 0);
        check("rst_addr_wdata_a", {addr_a, wdata_a}, 0);
        check("rst_counts_a", {elem_a, drop_a}, 0);
        check("rst_flags_a", {ovf_a, full_a, done_a}, 0);
        check("rst_flags_b", {en_b, ovf_b, full_b, done_b}, 0);

        // Single element
        for (int j = 0; j < 7; j++) d1[32*j +: 32] = 32'h1111_1111 * (j + 1);
        repeat (5) step();
        s = cyc;
        strobe_a(d1);
        repeat (14) step();
        check("t1_nwrites", la_addr.size(), 7);
        if (la_addr.size() >= 7) begin
            for (int j = 0; j < 7; j++) begin
                check($sformatf("t1_addr%0d", j), la_addr[j], 32'(4 * j));
                check($sformatf("t1_data%0d", j), la_data[j], 32'h1111_1111 * (j + 1));
                check($sformatf("t1_we%0d", j), la_we[j], 4'hF);
                check($sformatf("t1_cyc%0d", j), la_cyc[j] - s, 2 + j);
            end
        end
        check("t1_elements", elem_a, 1);
        check("t1_hold_addr", addr_a, 16'h18);
        check("t1_idle_en", en_a, 0);

        // Back-to-back burst of 11
        do_reset();
        for (int e = 0; e < 11; e++) begin
            tr_a = 1'b1; data_a = mk(16'hB000 + 16'(e));
            step();
        end
        tr_a = 1'b0;
        repeat (100) step();
        check("t2_nwrites", la_addr.size(), 70);
        bad = 0;
        for (int i = 0; i < la_addr.size() && i < 70; i++)
            if (la_addr[i] != 32'(4 * i) || la_data[i] != exp_word(16'hB000, i)) bad++;
        check("t2_seq_errors", bad, 0);
        if (la_addr.size() >= 70) check("t2_last_addr", la_addr[69], 32'h114);
        check("t2_elements", elem_a, 10);
        check("t2_dropped", drop_a, 1);
        check("t2_overflow", ovf_a, 1);
        check("t2_done", done_a, 0);

        // Repeat drain
        do_reset();
        for (int e = 0; e < 3; e++) begin
            tr_a = 1'b1; data_a = mk(16'hD000 + 16'(e));
            step();
        end
        tr_a = 1'b0;
        step();
        rep_a = 1'b1;
        repeat (40) step();
        check("t3_nwrites", la_addr.size(), 22);
        bad = 0;
        for (int i = 0; i < la_addr.size() && i < 21; i++)
            if (la_addr[i] != 32'(4 * i) || la_data[i] != exp_word(16'hD000, i)) bad++;
        check("t3_seq_errors", bad, 0);
        if (la_addr.size() >= 22) begin
            check("t3_marker_addr", la_addr[21], 32'h54);
            check("t3_marker_data", la_data[21], 32'hFFFF_FFFF);
        end
        check("t3_done", done_a, 1);
        strobe_a(mk(16'hDEAD));
        repeat (20) step();
        check("t3_after_nwrites", la_addr.size(), 22);
        check("t3_after_counts", {elem_a, drop_a}, {32'd3, 32'd0});
        check("t3_after_ovf", ovf_a, 0);

        // Reset mid-write
        do_reset();
        s = cyc;
        strobe_a(mk(16'hA000));
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("t5_en_after_rst", en_a, 0);
        check("t5_counts_after_rst", {elem_a, drop_a}, 0);
        check("t5_addr_after_rst", addr_a, 0);
        check("t5_nwrites", la_addr.size(), 4);
        do_reset();
        strobe_a(mk(16'hA100));
        repeat (12) step();
        check("t5_fresh_nwrites", la_addr.size(), 7);
        if (la_addr.size() >= 1) check("t5_fresh_addr0", la_addr[0], 0);
        if (la_data.size() >= 1) check("t5_fresh_data0", la_data[0], 32'hA100_0000);
        check("t5_fresh_elements", elem_a, 1);

`ifndef TRACE_BRAM_WRITER_WRAP_EN
        // Capacity on the 256-byte instance
        do_reset();
        for (int e = 0; e < 12; e++) begin
            tr_b = 1'b1; data_b = mk(16'hC000 + 16'(e));
            step();
            tr_b = 1'b0;
            repeat (9) step();
        end
        repeat (20) step();
        check("t4_nwrites", lb_addr.size(), 64);
        if (lb_addr.size() >= 64) begin
            check("t4_last_data_addr", lb_addr[62], 32'hF8);
            check("t4_last_data", lb_data[62], 32'hC008_0006);
            check("t4_marker_addr", lb_addr[63], 32'hFC);
            check("t4_marker_data", lb_data[63], 32'hFFFF_FFFF);
        end
        check("t4_elements", elem_b, 9);
        check("t4_full_done", {full_b, done_b}, 2'b11);
        check("t4_dropped", drop_b, 3);
        check("t4_overflow", ovf_b, 1);
`else
        // Ring wrap on the 256-byte instance
        do_reset();
        check("t6_rst_wrapped", wrapped_b, 0);
        for (int e = 0; e < 10; e++) begin
            tr_b = 1'b1; data_b = mk(16'hC000 + 16'(e));
            step();
            tr_b = 1'b0;
            repeat (9) step();
        end
        repeat (20) step();
        check("t6_nwrites", lb_addr.size(), 70);
        if (lb_addr.size() >= 70) begin
            check("t6_before_wrap_addr", lb_addr[62], 32'hF8);
            check("t6_wrap_addr", lb_addr[63], 32'h00);
            check("t6_wrap_data", lb_data[63], 32'hC009_0000);
            check("t6_last_addr", lb_addr[69], 32'h18);
        end
        check("t6_wrapped", wrapped_b, 1);
        check("t6_full", full_b, 0);
        check("t6_elements", elem_b, 10);
        check("t6_done_pre", done_b, 0);
        rep_b = 1'b1;
        repeat (10) step();
        check("t6_marker_n", lb_addr.size(), 71);
        if (lb_addr.size() >= 71) begin
            check("t6_marker_addr", lb_addr[70], 32'h1C);
            check("t6_marker_data", lb_data[70], 32'hFFFF_FFFF);
        end
        check("t6_done", done_b, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
